// File: rtl/if_fetch_stage_pkg.sv
// Shared declarations for the instruction-fetch stage: FSM encodings,
// bubble encoding and the default reset fetch address.
package if_fetch_stage_pkg;

  localparam logic [1:0] FS_BOOT  = 2'd0;
  localparam logic [1:0] FS_REQ   = 2'd1;
  localparam logic [1:0] FS_HOLD  = 2'd2;
  localparam logic [1:0] FS_DRAIN = 2'd3;

  localparam logic [31:0] INST_NOP     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Handshaked instruction-memory port: request/address held stable until
// the cycle in which the memory answers with imem_valid.
interface if_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_valid, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_valid, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage_npc.sv
// Redirect detection and next-PC selection: branch target beats jump
// target, otherwise the sequential successor of the current request.
module fetch_npc
  import if_fetch_stage_pkg::*;
(
  input  logic        PC_B,
  input  logic        PC_J,
  input  logic [31:0] br_target,
  input  logic [25:0] j_index,
  input  logic [31:0] IFID_pc4,
  input  logic [31:0] req_addr,
  output logic [31:0] npc,
  output logic        redirect
);

  logic [31:0] w_j_target;
  logic        w_unused;

  assign w_j_target = {IFID_pc4[31:28], j_index, 2'b00};
  assign redirect   = PC_B | PC_J;
  assign w_unused   = ^{IFID_pc4[27:0], br_target[1:0]};

  always_comb begin
    if (PC_B)      npc = word_align(br_target);
    else if (PC_J) npc = w_j_target;
    else           npc = req_addr + 32'd4;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS IF stage: owns the PC, runs the imem handshake FSM, buffers one
// word across stalls and drops responses made stale by a redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PC_Write,
  input  logic              IFID_Write,
  input  logic              IFID_Clear,
  input  logic              PC_B,
  input  logic [31:0]       br_target,
  input  logic              PC_J,
  input  logic [25:0]       j_index,
  if_fetch_stage_if.master  imem,
  output logic [31:0]       IFID_inst,
  output logic [31:0]       IFID_pc4,
  output logic              IFID_valid
);

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_addr, w_req_addr_nxt;
  logic [31:0] r_hold_inst, w_hold_inst_nxt;
  logic        r_hold_valid, w_hold_valid_nxt;
  logic [31:0] r_ifid_inst, w_ifid_inst_nxt;
  logic [31:0] r_ifid_pc4, w_ifid_pc4_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;

  logic [31:0] w_npc;
  logic        w_redirect;
  logic        w_req;
  logic        w_accept;
  logic        w_stall;

  fetch_npc u_npc (
    .PC_B      (PC_B),
    .PC_J      (PC_J),
    .br_target (br_target),
    .j_index   (j_index),
    .IFID_pc4  (r_ifid_pc4),
    .req_addr  (r_req_addr),
    .npc       (w_npc),
    .redirect  (w_redirect)
  );

  assign w_req          = (r_state == FS_REQ) || (r_state == FS_DRAIN);
  assign w_accept       = w_req & imem.imem_valid;
  assign w_stall        = ~PC_Write | ~IFID_Write;
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_req_addr;
  assign IFID_inst      = r_ifid_inst;
  assign IFID_pc4       = r_ifid_pc4;
  assign IFID_valid     = r_ifid_valid;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_req_addr_nxt   = r_req_addr;
    w_hold_inst_nxt  = r_hold_inst;
    w_hold_valid_nxt = r_hold_valid;
    // Cycles that deliver nothing insert a bubble unless ID is frozen.
    w_ifid_inst_nxt  = IFID_Write ? INST_NOP : r_ifid_inst;
    w_ifid_pc4_nxt   = IFID_Write ? 32'h0    : r_ifid_pc4;
    w_ifid_valid_nxt = IFID_Write ? 1'b0     : r_ifid_valid;

    case (r_state)
      FS_BOOT: begin
        w_pc_nxt       = w_redirect ? w_npc : r_pc;
        w_req_addr_nxt = w_redirect ? w_npc : r_pc;
        w_state_nxt    = FS_REQ;
      end
      FS_REQ: begin
        if (w_accept) begin
          if (w_redirect) begin
            w_pc_nxt       = w_npc;
            w_req_addr_nxt = w_npc;
          end else if (w_stall) begin
            w_hold_inst_nxt  = imem.imem_rdata;
            w_hold_valid_nxt = 1'b1;
            w_state_nxt      = FS_HOLD;
          end else begin
            w_ifid_inst_nxt  = imem.imem_rdata;
            w_ifid_pc4_nxt   = w_npc;
            w_ifid_valid_nxt = 1'b1;
            w_pc_nxt         = w_npc;
            w_req_addr_nxt   = w_npc;
          end
        end else if (w_redirect) begin
          // The old request stays on the bus until answered, then is dropped.
          w_pc_nxt    = w_npc;
          w_state_nxt = FS_DRAIN;
        end
      end
      FS_HOLD: begin
        if (w_redirect) begin
          w_hold_valid_nxt = 1'b0;
          w_pc_nxt         = w_npc;
          w_req_addr_nxt   = w_npc;
          w_state_nxt      = FS_REQ;
        end else if (!w_stall) begin
          w_ifid_inst_nxt  = r_hold_inst;
          w_ifid_pc4_nxt   = w_npc;
          w_ifid_valid_nxt = 1'b1;
          w_hold_valid_nxt = 1'b0;
          w_pc_nxt         = w_npc;
          w_req_addr_nxt   = w_npc;
          w_state_nxt      = FS_REQ;
        end
      end
      FS_DRAIN: begin
        w_pc_nxt = w_redirect ? w_npc : r_pc;
        if (w_accept) begin
          w_req_addr_nxt = w_redirect ? w_npc : r_pc;
          w_state_nxt    = FS_REQ;
        end
      end
      default: w_state_nxt = FS_BOOT;
    endcase

    if (w_redirect || IFID_Clear) begin
      w_ifid_inst_nxt  = INST_NOP;
      w_ifid_pc4_nxt   = 32'h0;
      w_ifid_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FS_BOOT;
      r_pc         <= RESET_PC;
      r_req_addr   <= RESET_PC;
      r_hold_valid <= 1'b0;
      r_ifid_inst  <= INST_NOP;
      r_ifid_pc4   <= 32'h0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_req_addr   <= w_req_addr_nxt;
      r_hold_valid <= w_hold_valid_nxt;
      r_ifid_inst  <= w_ifid_inst_nxt;
      r_ifid_pc4   <= w_ifid_pc4_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_hold_inst <= w_hold_inst_nxt;
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage against a memory model answering
// addr ^ 32'hFFFF_0000 after a programmable number of wait cycles.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_Write, IFID_Write, IFID_Clear, PC_B, PC_J;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic [31:0] IFID_inst, IFID_pc4;
  logic        IFID_valid;

  int          lat = 0;
  int          cnt = 0;
  logic        force_vld = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;

  if_fetch_stage_if imem_bus ();

  assign imem_bus.imem_valid = force_vld | (imem_bus.imem_req && (cnt >= lat));
  assign imem_bus.imem_rdata = imem_bus.imem_addr ^ 32'hFFFF_0000;

  always @(posedge clk) begin
    if (!imem_bus.imem_req || imem_bus.imem_valid) cnt <= 0;
    else                                         cnt <= cnt + 1;
  end

  if_fetch_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PC_Write   (PC_Write),
    .IFID_Write (IFID_Write),
    .IFID_Clear (IFID_Clear),
    .PC_B       (PC_B),
    .br_target  (br_target),
    .PC_J       (PC_J),
    .j_index    (j_index),
    .imem       (imem_bus),
    .IFID_inst  (IFID_inst),
    .IFID_pc4   (IFID_pc4),
    .IFID_valid (IFID_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},  {31'h0, imem_bus.imem_req}, 32'h0);
    chk({tag, "_inst"}, IFID_inst, 32'h0);
    chk({tag, "_pc4"},  IFID_pc4, 32'h0);
    chk({tag, "_vld"},  {31'h0, IFID_valid}, 32'h0);
    chk({tag, "_addr"}, imem_bus.imem_addr, 32'h0000_3000);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] inst,
                          input logic [31:0] pc4, input logic vld);
    chk({tag, "_inst"}, IFID_inst, inst);
    chk({tag, "_pc4"},  IFID_pc4, pc4);
    chk({tag, "_vld"},  {31'h0, IFID_valid}, {31'h0, vld});
  endtask

  initial begin
    rst_n = 1'b0; PC_Write = 1'b1; IFID_Write = 1'b1; IFID_Clear = 1'b0;
    PC_B = 1'b0; PC_J = 1'b0; br_target = 32'h0; j_index = 26'h0;

    repeat (2) step();
    chk_reset("rst");
    rst_n = 1'b1;
    chk("boot_req", {31'h0, imem_bus.imem_req}, 32'h0);
    step();
    chk("req_up", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("addr0", imem_bus.imem_addr, 32'h0000_3000);

    // zero-wait streaming
    step(); chk_ifid("seq0", 32'hFFFF_3000, 32'h0000_3004, 1'b1);
    step(); chk_ifid("seq1", 32'hFFFF_3004, 32'h0000_3008, 1'b1);
    step(); chk_ifid("seq2", 32'hFFFF_3008, 32'h0000_300C, 1'b1);
    chk("seq_addr", imem_bus.imem_addr, 32'h0000_300C);

    // three-cycle memory
    lat = 2;
    step(); chk("lat_addr1", imem_bus.imem_addr, 32'h0000_300C); chk_ifid("lat_b1", 32'h0, 32'h0, 1'b0);
    step(); chk("lat_addr2", imem_bus.imem_addr, 32'h0000_300C); chk_ifid("lat_b2", 32'h0, 32'h0, 1'b0);
    step(); chk_ifid("lat_acc", 32'hFFFF_300C, 32'h0000_3010, 1'b1);
    chk("lat_next", imem_bus.imem_addr, 32'h0000_3010);

    // stall at accept, two cycles
    lat = 0; PC_Write = 1'b0; IFID_Write = 1'b0;
    step(); chk("hold_req1", {31'h0, imem_bus.imem_req}, 32'h0); chk("hold_inst1", IFID_inst, 32'hFFFF_300C);
    step(); chk("hold_req2", {31'h0, imem_bus.imem_req}, 32'h0); chk_ifid("hold2", 32'hFFFF_300C, 32'h0000_3010, 1'b1);
    PC_Write = 1'b1; IFID_Write = 1'b1;
    step(); chk_ifid("rel", 32'hFFFF_3010, 32'h0000_3014, 1'b1);
    chk("rel_req", {31'h0, imem_bus.imem_req}, 32'h1);
    chk("rel_addr", imem_bus.imem_addr, 32'h0000_3014);

    // branch while a two-cycle fetch is outstanding
    lat = 1; PC_B = 1'b1; br_target = 32'h0000_3100;
    step(); chk("br_drain_addr", imem_bus.imem_addr, 32'h0000_3014); chk("br_bub", {31'h0, IFID_valid}, 32'h0);
    PC_B = 1'b0;
    step(); chk("br_tgt_addr", imem_bus.imem_addr, 32'h0000_3100); chk_ifid("br_disc", 32'h0, 32'h0, 1'b0);
    step(); chk("br_wait", {31'h0, IFID_valid}, 32'h0);
    step(); chk_ifid("br_acc", 32'hFFFF_3100, 32'h0000_3104, 1'b1);

    // branch at accept, then jal
    lat = 0; PC_B = 1'b1; br_target = 32'h0040_000C;
    step(); chk("br2_addr", imem_bus.imem_addr, 32'h0040_000C); chk("br2_bub", {31'h0, IFID_valid}, 32'h0);
    PC_B = 1'b0;
    step(); chk_ifid("br2_acc", 32'hFFBF_000C, 32'h0040_0010, 1'b1);
    PC_J = 1'b1; j_index = 26'h10_0004;
    step(); chk("j_addr", imem_bus.imem_addr, 32'h0040_0010); chk_ifid("j_bub", 32'h0, 32'h0, 1'b0);
    PC_J = 1'b0;
    step(); chk_ifid("j_acc", 32'hFFBF_0010, 32'h0040_0014, 1'b1);
    PC_J = 1'b1; j_index = 26'h000_0C40;
    step(); chk("j2_addr", imem_bus.imem_addr, 32'h0000_3100);
    PC_B = 1'b1; br_target = 32'h0000_3200;
    step(); chk("bj_addr", imem_bus.imem_addr, 32'h0000_3200);
    PC_B = 1'b0; PC_J = 1'b0;

    // reset during DRAIN, late valid ignored
    lat = 3; PC_B = 1'b1; br_target = 32'h0000_3300;
    step(); chk("dr_req", {31'h0, imem_bus.imem_req}, 32'h1); chk("dr_addr", imem_bus.imem_addr, 32'h0000_3200);
    PC_B = 1'b0; rst_n = 1'b0;
    step(); chk_reset("rst_dr");
    rst_n = 1'b1; force_vld = 1'b1;
    step(); chk("dr_restart", imem_bus.imem_addr, 32'h0000_3000); chk("dr_late", {31'h0, IFID_valid}, 32'h0);
    force_vld = 1'b0; lat = 0;
    step(); chk_ifid("dr_acc", 32'hFFFF_3000, 32'h0000_3004, 1'b1);

    // reset during HOLD
    PC_Write = 1'b0;
    step(); chk("hd_req", {31'h0, imem_bus.imem_req}, 32'h0);
    rst_n = 1'b0; force_vld = 1'b1;
    step(); chk_reset("rst_hd");
    rst_n = 1'b1; PC_Write = 1'b1;
    step(); chk("hd_restart", imem_bus.imem_addr, 32'h0000_3000); chk("hd_late", {31'h0, IFID_valid}, 32'h0);
    force_vld = 1'b0;
    step(); chk_ifid("hd_acc", 32'hFFFF_3000, 32'h0000_3004, 1'b1);

    // IFID_Clear overrides a frozen IF/ID
    lat = 2; PC_Write = 1'b0; IFID_Write = 1'b0; IFID_Clear = 1'b1;
    step(); chk_ifid("clr", 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
